interface_dht11_uc: RTL

//  Control unit for the DHT11 measurement interface datapath (delay, timeout and retry counters, temperature/humidity registers, 16-bit serial receiver).
//  On a start request it sends the measurement trigger, then waits for the temperature frame and then the humidity frame, loading each into its register.

---
 rtl/interface_dht11_uc_if.sv | 34 +++
 rtl/interface_dht11_uc.sv | 120 ++++++++++++
 2 files changed

// File: rtl/interface_dht11_uc_if.sv
// Signal bundle between the DHT11 control unit, the system FSM and the datapath.
// master = control unit side, slave = system FSM / datapath side.
interface interface_dht11_uc_if;
  logic       iniciar;
  logic       fim_delay_sinal;
  logic       fim_recepcao_medida;
  logic       medida_ok;
  logic       timeout;
  logic       fim_tentativas;
  logic       conta_delay_sinal;
  logic       pede_medida;
  logic       conta_timeout;
  logic       zera_timeout;
  logic       conta_tentativas;
  logic       zera_tentativas;
  logic       load_temperatura;
  logic       load_umidade;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, fim_delay_sinal, fim_recepcao_medida, medida_ok, timeout, fim_tentativas,
    output conta_delay_sinal, pede_medida, conta_timeout, zera_timeout, conta_tentativas,
           zera_tentativas, load_temperatura, load_umidade, ocupado, pronto, erro, db_estado
  );

  modport slave (
    output iniciar, fim_delay_sinal, fim_recepcao_medida, medida_ok, timeout, fim_tentativas,
    input  conta_delay_sinal, pede_medida, conta_timeout, zera_timeout, conta_tentativas,
           zera_tentativas, load_temperatura, load_umidade, ocupado, pronto, erro, db_estado
  );
endinterface

// File: rtl/interface_dht11_uc.sv
// Moore control unit for the DHT11 measurement datapath: trigger, capture
// temperature (and optionally humidity), retry up to 4 attempts, then report error.
module interface_dht11_uc #(
  parameter bit MEDE_UMIDADE = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  interface_dht11_uc_if.master  io_bus
);

  typedef enum logic [3:0] {
    INICIAL       = 4'b0000,
    ENVIA_SINAL   = 4'b0001,
    ESPERA_TEMP   = 4'b0010,
    ARMAZENA_TEMP = 4'b0011,
    ESPERA_UMID   = 4'b0100,
    ARMAZENA_UMID = 4'b0101,
    FINAL         = 4'b0110,
    FALHA         = 4'b0111,
    ERRO          = 4'b1000
  } t_estado;

  t_estado r_estado;
  t_estado w_estado_next;
  logic    r_zera_timeout;
  logic    w_zera_timeout_next;

  // States in which the timeout counter is held clear.
  function automatic logic f_zera_timeout(input t_estado e);
    return (e == INICIAL) || (e == ARMAZENA_TEMP) || (e == ARMAZENA_UMID) ||
           (e == FINAL)   || (e == FALHA)         || (e == ERRO);
  endfunction

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_estado       <= INICIAL;
      r_zera_timeout <= 1'b1;
    end else begin
      r_estado       <= w_estado_next;
      r_zera_timeout <= w_zera_timeout_next;
    end
  end

  always_comb begin
    w_estado_next = r_estado;
    case (r_estado)
      INICIAL:       if (io_bus.iniciar) w_estado_next = ENVIA_SINAL;
      ENVIA_SINAL:   if (io_bus.fim_delay_sinal) w_estado_next = ESPERA_TEMP;
      // A received frame takes priority over a coincident timeout.
      ESPERA_TEMP: begin
        if (io_bus.fim_recepcao_medida)
          w_estado_next = io_bus.medida_ok ? ARMAZENA_TEMP : FALHA;
        else if (io_bus.timeout)
          w_estado_next = FALHA;
      end
      ARMAZENA_TEMP: w_estado_next = MEDE_UMIDADE ? ESPERA_UMID : FINAL;
      ESPERA_UMID: begin
        if (io_bus.fim_recepcao_medida)
          w_estado_next = io_bus.medida_ok ? ARMAZENA_UMID : FALHA;
        else if (io_bus.timeout)
          w_estado_next = FALHA;
      end
      ARMAZENA_UMID: w_estado_next = FINAL;
      FINAL:         w_estado_next = INICIAL;
      FALHA:         w_estado_next = io_bus.fim_tentativas ? ERRO : ENVIA_SINAL;
      ERRO:          if (io_bus.iniciar) w_estado_next = ENVIA_SINAL;
      default:       w_estado_next = INICIAL;
    endcase
    w_zera_timeout_next = f_zera_timeout(w_estado_next);
  end

  always_comb begin
    io_bus.conta_delay_sinal = 1'b0;
    io_bus.pede_medida       = 1'b0;
    io_bus.conta_timeout     = 1'b0;
    io_bus.conta_tentativas  = 1'b0;
    io_bus.zera_tentativas   = 1'b0;
    io_bus.load_temperatura  = 1'b0;
    io_bus.load_umidade      = 1'b0;
    io_bus.ocupado           = 1'b0;
    io_bus.pronto            = 1'b0;
    io_bus.erro              = 1'b0;
    io_bus.zera_timeout      = r_zera_timeout;
    io_bus.db_estado         = r_estado;
    case (r_estado)
      INICIAL:       io_bus.zera_tentativas = 1'b1;
      ENVIA_SINAL: begin
        io_bus.pede_medida       = 1'b1;
        io_bus.conta_delay_sinal = 1'b1;
        io_bus.ocupado           = 1'b1;
      end
      ESPERA_TEMP, ESPERA_UMID: begin
        io_bus.conta_timeout = 1'b1;
        io_bus.ocupado       = 1'b1;
      end
      ARMAZENA_TEMP: begin
        io_bus.load_temperatura = 1'b1;
        io_bus.ocupado          = 1'b1;
      end
      ARMAZENA_UMID: begin
        io_bus.load_umidade = MEDE_UMIDADE;
        io_bus.ocupado      = 1'b1;
      end
      FINAL: begin
        io_bus.pronto  = 1'b1;
        io_bus.ocupado = 1'b1;
      end
      FALHA: begin
        io_bus.conta_tentativas = 1'b1;
        io_bus.ocupado          = 1'b1;
      end
      ERRO: begin
        io_bus.erro            = 1'b1;
        io_bus.zera_tentativas = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
